// File: rtl/icache_nway.sv
// N-way read-only instruction cache: FIFO replacement, latched miss context, fills aborted by flush.
// Hit/miss counters are built only when ICACHE_PERF_CNT_EN is defined.
// Handshake: a fetch is held (p_strobe_i, p_addr_i stable) until p_ready_o; p_instr_o is valid the cycle after.
module icache_nway #(
   parameter int XLEN       = 32,
   parameter int CACHE_SIZE = 64,
   parameter int CLSIZE     = 256,
   parameter int N_WAYS     = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p_strobe_i,
   input  logic [XLEN-1:0]   p_addr_i,
   input  logic              p_flush_i,
   output logic              p_ready_o,
   output logic [XLEN-1:0]   p_instr_o,
   input  logic              d_flushing_i,
   output logic              m_strobe_o,
   output logic [XLEN-1:0]   m_addr_o,
   input  logic              m_ready_i,
   input  logic [CLSIZE-1:0] m_data_i,
`ifdef ICACHE_PERF_CNT_EN
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o,
`endif
   output logic [1:0]        dbg_state_o
);

   localparam int N_LINES   = CACHE_SIZE * 8192 / (N_WAYS * CLSIZE);
   localparam int N_WORDS   = CLSIZE / 32;
   localparam int WORD_BITS = $clog2(N_WORDS);
   localparam int LINE_BITS = $clog2(N_LINES);
   localparam int TAG_BITS  = XLEN - LINE_BITS - WORD_BITS - 2;
   localparam int WAY_BITS  = $clog2(N_WAYS);
   localparam int LADDR_W   = XLEN - WORD_BITS - 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_NEXT  = 2'd1,
      S_RDMEM = 2'd2,
      S_RDFIN = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [WORD_BITS-1:0] cur_off;
   logic [LINE_BITS-1:0] cur_idx;
   logic [TAG_BITS-1:0]  cur_tag;
   logic [LADDR_W-1:0]   cur_line;
   logic                 unused_addr_bits;

   assign cur_off          = p_addr_i[WORD_BITS+1:2];
   assign cur_idx          = p_addr_i[WORD_BITS+2 +: LINE_BITS];
   assign cur_tag          = p_addr_i[XLEN-1 -: TAG_BITS];
   assign cur_line         = p_addr_i[XLEN-1:WORD_BITS+2];
   assign unused_addr_bits = ^p_addr_i[1:0];

   logic [N_WAYS-1:0]   valid_q [N_LINES];
   logic [TAG_BITS-1:0] tag_q   [N_LINES][N_WAYS];
   logic [WAY_BITS-1:0] fifo_q  [N_LINES];
   logic [CLSIZE-1:0]   rd_lines [N_WAYS];

   // Latched miss context: the fill uses only these, never the live fetch address
   logic [LADDR_W-1:0]   miss_line_q;
   logic [WORD_BITS-1:0] miss_off_q;
   logic [WAY_BITS-1:0]  victim_q;
   logic                 abort_q;
   logic [LINE_BITS-1:0] prev_idx_q;

   logic [LINE_BITS-1:0] miss_idx;
   logic [TAG_BITS-1:0]  miss_tag;

   assign miss_idx = miss_line_q[LINE_BITS-1:0];
   assign miss_tag = miss_line_q[LADDR_W-1 -: TAG_BITS];

   function automatic logic [31:0] pick_word(input logic [CLSIZE-1:0] line,
                                             input logic [WORD_BITS-1:0] off);
      pick_word = '0;
      for (int k = 0; k < N_WORDS; k++) begin
         if (off == WORD_BITS'(k)) pick_word = line[CLSIZE-1-32*k -: 32];
      end
   endfunction

   logic [N_WAYS-1:0] hit_vec;
   logic              hit_one;
   logic              idx_match;
   logic [CLSIZE-1:0] hit_line;
   logic [31:0]       hit_word;
   logic [31:0]       fill_word;

   always_comb begin
      hit_vec  = '0;
      hit_line = '0;
      for (int w = 0; w < N_WAYS; w++) begin
         if (valid_q[cur_idx][w] && (tag_q[cur_idx][w] == cur_tag)) hit_vec[w] = 1'b1;
      end
      for (int w = 0; w < N_WAYS; w++) begin
         if (hit_vec[w]) hit_line = hit_line | rd_lines[w];
      end
      hit_one   = (hit_vec != '0) && ((hit_vec & (hit_vec - 1'b1)) == '0);
      idx_match = (cur_idx == prev_idx_q);
      // Multiple matching ways never deliver data
      hit_word  = hit_one ? pick_word(hit_line, cur_off) : '0;
      fill_word = pick_word(m_data_i, miss_off_q);
   end

   logic              take_miss;
   logic              hit_serve;
   logic              fill_ready;
   logic              fill_we;
   logic [XLEN-1:0]   m_addr_d;

   always_comb begin
      state_d    = state_q;
      p_ready_o  = 1'b0;
      take_miss  = 1'b0;
      hit_serve  = 1'b0;
      fill_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (p_strobe_i) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (p_strobe_i) begin
               if (hit_one) begin
                  // SRAM output only reflects the live set once the index has been stable a cycle
                  if (idx_match) begin
                     p_ready_o = 1'b1;
                     hit_serve = 1'b1;
                  end
               end else if (!d_flushing_i) begin
                  take_miss = 1'b1;
                  state_d   = S_RDMEM;
               end
            end
         end
         S_RDMEM: begin
            if (m_ready_i) begin
               p_ready_o  = 1'b1;
               fill_ready = 1'b1;
               state_d    = S_RDFIN;
            end
         end
         S_RDFIN: begin
            state_d = S_NEXT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign fill_we = fill_ready && !rst_i;

   always_comb begin
      m_addr_d = '0;
      if (take_miss) begin
         m_addr_d = {cur_line, {(WORD_BITS+2){1'b0}}};
      end else if ((state_q == S_RDMEM) && (state_d == S_RDMEM)) begin
         m_addr_d = {miss_line_q, {(WORD_BITS+2){1'b0}}};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         prev_idx_q  <= '0;
         miss_line_q <= '0;
         miss_off_q  <= '0;
         victim_q    <= '0;
         abort_q     <= 1'b0;
         p_instr_o   <= '0;
         m_strobe_o  <= 1'b0;
         m_addr_o    <= '0;
      end else begin
         state_q    <= state_d;
         prev_idx_q <= cur_idx;
         if (take_miss) begin
            miss_line_q <= cur_line;
            miss_off_q  <= cur_off;
            victim_q    <= fifo_q[cur_idx];
            abort_q     <= 1'b0;
         end else if ((state_q == S_RDMEM) && p_flush_i) begin
            abort_q <= 1'b1;
         end
         if (hit_serve) begin
            p_instr_o <= XLEN'(hit_word);
         end else if (fill_ready) begin
            p_instr_o <= XLEN'(fill_word);
         end
         m_strobe_o <= (state_q == S_RDMEM) && (state_d == S_RDMEM);
         m_addr_o   <= m_addr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int l = 0; l < N_LINES; l++) begin
            valid_q[l] <= '0;
            fifo_q[l]  <= '0;
            for (int w = 0; w < N_WAYS; w++) tag_q[l][w] <= '0;
         end
      end else begin
         if (fill_we) tag_q[miss_idx][victim_q] <= miss_tag;
         // A flush seen at any point of the fill keeps the new line invalid
         if (p_flush_i) begin
            for (int l = 0; l < N_LINES; l++) valid_q[l] <= '0;
         end else if (fill_we && !abort_q) begin
            valid_q[miss_idx][victim_q] <= 1'b1;
         end
         if (state_q == S_RDFIN) fifo_q[miss_idx] <= fifo_q[miss_idx] + 1'b1;
      end
   end

   for (genvar w = 0; w < N_WAYS; w++) begin : g_way
      logic [CLSIZE-1:0] mem [N_LINES];
      logic [CLSIZE-1:0] rd_q;

      always_ff @(posedge clk_i) begin
         if (fill_we && (victim_q == WAY_BITS'(w))) mem[miss_idx] <= m_data_i;
         rd_q <= mem[cur_idx];
      end

      assign rd_lines[w] = rd_q;
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (hit_serve) hit_cnt_o <= hit_cnt_o + 32'd1;
         if (take_miss) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: table of fetches with expected hit/miss, scoreboard of instruction words,
// plus hand-written flush, d-flush, spurious-ready and reset-mid-fill sequences.
module tb_icache_nway;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         p_strobe_i;
  logic [31:0]  p_addr_i;
  logic         p_flush_i;
  logic         p_ready_o;
  logic [31:0]  p_instr_o;
  logic         d_flushing_i;
  logic         m_strobe_o;
  logic [31:0]  m_addr_o;
  logic         m_ready_i;
  logic [255:0] m_data_i;
  logic [1:0]   dbg_state_o;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  icache_nway dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p_strobe_i   (p_strobe_i),
    .p_addr_i     (p_addr_i),
    .p_flush_i    (p_flush_i),
    .p_ready_o    (p_ready_o),
    .p_instr_o    (p_instr_o),
    .d_flushing_i (d_flushing_i),
    .m_strobe_o   (m_strobe_o),
    .m_addr_o     (m_addr_o),
    .m_ready_i    (m_ready_i),
    .m_data_i     (m_data_i),
`ifdef ICACHE_PERF_CNT_EN
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o),
`endif
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    bit          miss;
    int          fmode;     // 0 none, 1 flush before m_ready, 2 flush with m_ready
    bit          pre_flush;
  } vec_t;

  vec_t        vecs [24];
  logic [31:0] exp_q [$];
  int          n_checks   = 0;
  int          n_errors   = 0;
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory: line at 0x100 holds 0xA000_0000+k, every other line is distinct
  function automatic logic [31:0] mem_word(input logic [31:0] line_a, input int k);
    return 32'hA000_0000 + ((line_a ^ 32'h100) << 3) + 32'(k);
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] line_a);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[255-32*k -: 32] = mem_word(line_a, k);
    return l;
  endfunction

  // ---------------- driver ----------------
  task automatic fetch(input logic [31:0] addr, input bit exp_miss, input int fmode,
                       input bit pre_flush, input int dflush);
    logic [31:0] line_a;
    logic [31:0] exp_w;
    bit seen, ready, responded, flushed, df_viol;
    int cyc, cnt, lat, rdy_cyc;
    line_a    = {addr[31:5], 5'b0};
    seen      = 0;
    ready     = 0;
    responded = 0;
    flushed   = 0;
    df_viol   = 0;
    cyc       = 0;
    cnt       = 0;
    rdy_cyc   = 0;
    lat       = (fmode == 1) ? $urandom_range(1, 3) : $urandom_range(0, 3);
    @(posedge clk_i); #1;
    if (pre_flush) begin
      p_flush_i = 1'b1;
      @(posedge clk_i); #1;
      p_flush_i = 1'b0;
    end
    exp_q.push_back(mem_word(line_a, int'(addr[4:2])));
    if (exp_miss) exp_misses++; else exp_hits++;
    p_addr_i     = addr;
    p_strobe_i   = 1'b1;
    d_flushing_i = (dflush > 0);
    while (!ready && cyc < 200) begin
      @(negedge clk_i);
      if (d_flushing_i && m_strobe_o) df_viol = 1;
      if (m_strobe_o && !seen) begin
        seen = 1;
        cnt  = lat;
        check($sformatf("m_addr@%h", addr), m_addr_o, line_a);
      end
      if (p_ready_o) begin
        ready   = 1;
        rdy_cyc = cyc;
        if (exp_miss) check($sformatf("ready_with_mready@%h", addr), m_ready_i, 1'b1);
      end
      @(posedge clk_i); #1;
      m_ready_i = 1'b0;
      p_flush_i = 1'b0;
      if (ready) begin
        p_strobe_i = 1'b0;
      end else begin
        cyc++;
        if (cyc >= dflush) d_flushing_i = 1'b0;
        if (seen && !responded) begin
          if (fmode == 1 && !flushed) begin
            p_flush_i = 1'b1;
            flushed   = 1;
          end
          if (cnt == 0) begin
            m_ready_i = 1'b1;
            m_data_i  = mem_line(line_a);
            responded = 1;
            if (fmode == 2) p_flush_i = 1'b1;
          end else begin
            cnt--;
          end
        end
      end
    end
    p_strobe_i   = 1'b0;
    d_flushing_i = 1'b0;
    check($sformatf("ready@%h", addr), ready, 1'b1);
    check($sformatf("miss@%h", addr), seen, exp_miss);
    if (dflush > 0) check($sformatf("dflush_no_strobe@%h", addr), df_viol, 1'b0);
    if (!ready) begin
      void'(exp_q.pop_front());
    end else begin
      @(negedge clk_i);
      exp_w = exp_q.pop_front();
      check($sformatf("instr@%h", addr), p_instr_o, exp_w);
      if (exp_miss) begin
        check($sformatf("strobe_drop@%h", addr), m_strobe_o, 1'b0);
        check($sformatf("m_addr_idle@%h", addr), m_addr_o, 32'h0);
      end else begin
        check($sformatf("hit_latency@%h", addr), (rdy_cyc <= 1), 1'b1);
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin : main
    bit          seen;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] miss_before;
`endif
    vecs[0]  = '{32'h0000_0104, 1, 0, 0};
    vecs[1]  = '{32'h0000_011C, 0, 0, 0};
    vecs[2]  = '{32'h0000_0000, 1, 0, 0};
    vecs[3]  = '{32'h0000_4000, 1, 0, 0};
    vecs[4]  = '{32'h0000_8000, 1, 0, 0};
    vecs[5]  = '{32'h0000_C000, 1, 0, 0};
    vecs[6]  = '{32'h0001_0000, 1, 0, 0};
    vecs[7]  = '{32'h0000_4000, 0, 0, 0};
    vecs[8]  = '{32'h0000_0000, 1, 0, 0};
    vecs[9]  = '{32'h0000_8004, 0, 0, 0};
    vecs[10] = '{32'h0000_C01C, 0, 0, 0};
    vecs[11] = '{32'h0001_0008, 0, 0, 0};
    vecs[12] = '{32'h0000_0108, 0, 0, 0};
    vecs[13] = '{32'h0000_0000, 1, 0, 1};
    vecs[14] = '{32'h0000_8000, 1, 0, 0};
    vecs[15] = '{32'h0000_C000, 1, 0, 0};
    vecs[16] = '{32'h0001_0000, 1, 0, 0};
    vecs[17] = '{32'h0000_0104, 1, 0, 0};
    vecs[18] = '{32'h0002_0000, 1, 1, 0};
    vecs[19] = '{32'h0002_0000, 1, 0, 0};
    vecs[20] = '{32'h0002_0000, 0, 0, 0};
    vecs[21] = '{32'h0000_0024, 1, 2, 0};
    vecs[22] = '{32'h0000_0024, 1, 0, 0};
    vecs[23] = '{32'h0000_0028, 0, 0, 0};

    rst_i        = 1'b1;
    p_strobe_i   = 1'b0;
    p_addr_i     = '0;
    p_flush_i    = 1'b0;
    d_flushing_i = 1'b0;
    m_ready_i    = 1'b0;
    m_data_i     = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_p_ready", p_ready_o, 1'b0);
    check("rst_p_instr", p_instr_o, 32'h0);
    check("rst_m_strobe", m_strobe_o, 1'b0);
    check("rst_m_addr", m_addr_o, 32'h0);
    check("rst_state", dbg_state_o, 2'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("rst_hit_cnt", hit_cnt_o, 32'h0);
    check("rst_miss_cnt", miss_cnt_o, 32'h0);
`endif

    for (int i = 0; i < 24; i++) begin
      fetch(vecs[i].addr, vecs[i].miss, vecs[i].fmode, vecs[i].pre_flush, 0);
    end

    // D-cache flushing holds off the miss request for 10 cycles
`ifdef ICACHE_PERF_CNT_EN
    miss_before = miss_cnt_o;
`endif
    fetch(32'h0004_0000, 1, 0, 0, 10);
`ifdef ICACHE_PERF_CNT_EN
    check("dflush_miss_cnt", miss_cnt_o - miss_before, 32'd1);
`endif

    // m_ready_i outside a fill: no ready, no SRAM write
    @(posedge clk_i); #1;
    m_ready_i = 1'b1;
    m_data_i  = {8{32'hDEAD_BEEF}};
    @(negedge clk_i);
    check("spurious_mready_ready", p_ready_o, 1'b0);
    @(posedge clk_i); #1;
    m_ready_i = 1'b0;
    fetch(32'h0004_0014, 0, 0, 0, 0);

`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt_total", hit_cnt_o, 32'(exp_hits));
    check("miss_cnt_total", miss_cnt_o, 32'(exp_misses));
`endif

    // Reset in the middle of a fill, with a line arriving in the reset cycle
    @(posedge clk_i); #1;
    p_addr_i   = 32'h0008_0000;
    p_strobe_i = 1'b1;
    seen       = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (m_strobe_o) seen = 1;
    end
    check("rstfill_req", seen, 1'b1);
    @(posedge clk_i); #1;
    rst_i      = 1'b1;
    m_ready_i  = 1'b1;
    m_data_i   = mem_line(32'h0008_0000);
    p_strobe_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i     = 1'b0;
    m_ready_i = 1'b0;
    @(negedge clk_i);
    check("rstfill_m_strobe", m_strobe_o, 1'b0);
    check("rstfill_m_addr", m_addr_o, 32'h0);
    check("rstfill_state", dbg_state_o, 2'd0);
    check("rstfill_p_instr", p_instr_o, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
    check("rstfill_hit_cnt", hit_cnt_o, 32'h0);
`endif
    fetch(32'h0008_0000, 1, 0, 0, 0);
    fetch(32'h0000_0104, 1, 0, 0, 0);
    fetch(32'h0008_001C, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
